pat_chg_seq: RTL and testbench

//  Downstream of the button/pattern-select stage. Consumes the 8-bit pattern number and hands it to the pattern generator.
//  On every change it blanks the panel, waits, loads the new number through a req/ack handshake, settles, then unblanks.

---
 rtl/pat_chg_seq.sv | 164 ++++++++++++++++
 tb/tb_pat_chg_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pat_chg_seq.sv
// pat_chg_seq
//   Sequences a pattern-number change into the pattern generator without tearing:
//   blank the panel, wait, load the new number over a req/ack handshake, settle, unblank.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   dis_sn_in  in   [7:0] requested pattern number (synchronous to clk)
//   pat_ack    in   pattern generator accepted pat_sn (level or pulse)
//   clr_err    in   clears err_tmo
//   pat_sn     out  [7:0] committed pattern number
//   pat_load   out  1-cycle load strobe, pat_sn valid with it
//   blank_o    out  1 = force black output
//   busy       out  1 = change sequence in progress
//   err_tmo    out  sticky ack-timeout flag
module pat_chg_seq #(
    parameter int unsigned CNT1US     = 81,
    parameter int unsigned BLANK_US   = 2000,
    parameter int unsigned SETTLE_US  = 1000,
    parameter int unsigned ACK_TMO_US = 10000,
    parameter logic [7:0]  PATMIN     = 8'd127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dis_sn_in,
    input  logic       pat_ack,
    input  logic       clr_err,
    output logic [7:0] pat_sn,
    output logic       pat_load,
    output logic       blank_o,
    output logic       busy,
    output logic       err_tmo
);

    localparam int unsigned PW = (CNT1US > 1) ? $clog2(CNT1US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'((CNT1US > 0) ? CNT1US - 1 : 0);

    localparam logic [15:0] BLANK_P  = BLANK_US[15:0];
    localparam logic [15:0] SETTLE_P = SETTLE_US[15:0];
    localparam logic [15:0] TMO_P    = ACK_TMO_US[15:0];

    // Terminal us-count per wait; a zero wait is treated as 1 us.
    localparam logic [15:0] BLANK_LAST  = (BLANK_P  == 16'd0) ? 16'd0 : BLANK_P  - 16'd1;
    localparam logic [15:0] SETTLE_LAST = (SETTLE_P == 16'd0) ? 16'd0 : SETTLE_P - 16'd1;
    localparam logic [15:0] TMO_LAST    = (TMO_P    == 16'd0) ? 16'd0 : TMO_P    - 16'd1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BLANK  = 2'd1;
    localparam logic [1:0] WACK   = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [7:0]    tgt_q, tgt_d;
    logic [7:0]    pat_sn_q, pat_sn_d;
    logic          load_q, load_d;
    logic          blank_q, blank_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   us_q, us_d;

    logic tick;
    logic restart;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        pat_sn_d = pat_sn_q;
        load_d   = 1'b0;
        blank_d  = blank_q;
        busy_d   = busy_q;
        err_d    = err_q & ~clr_err;
        restart  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dis_sn_in != pat_sn_q) begin
                    state_d = BLANK;
                    tgt_d   = dis_sn_in;
                    blank_d = 1'b1;
                    busy_d  = 1'b1;
                    restart = 1'b1;
                end
            end
            BLANK: begin
                // A newer request restarts the blank wait; the latest value wins.
                if (dis_sn_in != tgt_q) begin
                    tgt_d   = dis_sn_in;
                    restart = 1'b1;
                end else if (tick && (us_q >= BLANK_LAST)) begin
                    state_d  = WACK;
                    pat_sn_d = tgt_q;
                    load_d   = 1'b1;
                    restart  = 1'b1;
                end
            end
            WACK: begin
                if (pat_ack) begin
                    state_d = SETTLE;
                    restart = 1'b1;
                end else if (tick && (us_q >= TMO_LAST)) begin
                    // Timeout set overrides a simultaneous clr_err.
                    err_d   = 1'b1;
                    state_d = SETTLE;
                    restart = 1'b1;
                end
            end
            SETTLE: begin
                if (tick && (us_q >= SETTLE_LAST)) begin
                    state_d = IDLE;
                    blank_d = 1'b0;
                    busy_d  = 1'b0;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                restart = 1'b1;
            end
        endcase

        // Time base restarts on every state entry and rests in IDLE.
        if (restart || (state_q == IDLE)) begin
            pre_d = '0;
            us_d  = 16'd0;
        end else begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            us_d  = (tick && (us_q != 16'hFFFF)) ? us_q + 16'd1 : us_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tgt_q    <= PATMIN;
            pat_sn_q <= PATMIN;
            load_q   <= 1'b0;
            blank_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            pre_q    <= '0;
            us_q     <= 16'd0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            pat_sn_q <= pat_sn_d;
            load_q   <= load_d;
            blank_q  <= blank_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            pre_q    <= pre_d;
            us_q     <= us_d;
        end
    end

    assign pat_sn   = pat_sn_q;
    assign pat_load = load_q;
    assign blank_o  = blank_q;
    assign busy     = busy_q;
    assign err_tmo  = err_q;

endmodule

// File: tb/tb_pat_chg_seq.sv
// tb_pat_chg_seq
//   Self-checking bench for pat_chg_seq with short timing parameters.
//   Expected loads (value and cycle) are queued when a change is driven and
//   popped by a monitor when pat_load fires.
module tb_pat_chg_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] dis_sn_in;
    logic       pat_ack;
    logic       clr_err;
    logic [7:0] pat_sn;
    logic       pat_load;
    logic       blank_o;
    logic       busy;
    logic       err_tmo;

    logic ack_gen;
    logic ack_force;
    logic ack_en;
    int   ack_dly;

    assign pat_ack = ack_gen | ack_force;

    typedef struct {
        logic [7:0] sn;
        int         due;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_err;
    int   cyc;
    logic prev_load;

    pat_chg_seq #(
        .CNT1US     (4),
        .BLANK_US   (3),
        .SETTLE_US  (2),
        .ACK_TMO_US (5),
        .PATMIN     (8'd127)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dis_sn_in (dis_sn_in),
        .pat_ack   (pat_ack),
        .clr_err   (clr_err),
        .pat_sn    (pat_sn),
        .pat_load  (pat_load),
        .blank_o   (blank_o),
        .busy      (busy),
        .err_tmo   (err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic go_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", {31'd0, busy}, 0);
        @(negedge clk);
    endtask

    // Scoreboard monitor: every load must match the next queued expectation.
    initial prev_load = 1'b0;
    always @(negedge clk) begin
        if (pat_load === 1'b1) begin
            chk("load_1cyc", {31'd0, prev_load}, 0);
            if (q.size() == 0) begin
                chk("load_unexpected", {24'd0, pat_sn}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("load_sn", {24'd0, pat_sn}, {24'd0, e.sn});
                chk("load_cyc", cyc, e.due);
            end
        end
        prev_load = pat_load;
    end

    // Acknowledge responder: ack_dly cycles after the load strobe, 1 cycle wide.
    initial begin
        ack_gen = 1'b0;
        forever begin
            @(negedge clk);
            ack_gen = 1'b0;
            if (ack_en && pat_load === 1'b1) begin
                repeat (ack_dly) @(negedge clk);
                ack_gen = 1'b1;
            end
        end
    end

    initial begin
        int t;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        dis_sn_in = 8'd127;
        clr_err   = 1'b0;
        ack_force = 1'b0;
        ack_en    = 1'b1;
        ack_dly   = 2;

        // 1: reset
        repeat (2) @(negedge clk);
        chk("rst_pat_sn", {24'd0, pat_sn}, 127);
        chk("rst_blank", {31'd0, blank_o}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_load", {31'd0, pat_load}, 0);
        chk("rst_err", {31'd0, err_tmo}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {31'd0, busy}, 0);

        // 2: basic change with ack two cycles after load
        t = cyc;
        dis_sn_in = 8'd128;
        q.push_back('{sn: 8'd128, due: t + 13});
        go_to(t + 1);
        chk("t2_blank_on", {31'd0, blank_o}, 1);
        chk("t2_busy_on", {31'd0, busy}, 1);
        go_to(t + 12);
        chk("t2_sn_stable", {24'd0, pat_sn}, 127);
        go_to(t + 23);
        chk("t2_blank_hold", {31'd0, blank_o}, 1);
        go_to(t + 24);
        chk("t2_blank_off", {31'd0, blank_o}, 0);
        chk("t2_busy_off", {31'd0, busy}, 0);
        chk("t2_sn", {24'd0, pat_sn}, 128);

        // 3: change mid-BLANK restarts the wait, single load of latest value
        repeat (2) @(negedge clk);
        t = cyc;
        dis_sn_in = 8'd100;
        go_to(t + 5);
        dis_sn_in = 8'd129;
        q.push_back('{sn: 8'd129, due: t + 18});
        wait_idle();
        chk("t3_sn", {24'd0, pat_sn}, 129);

        // 3b: restart back to the current value still reloads it
        t = cyc;
        dis_sn_in = 8'd50;
        go_to(t + 3);
        dis_sn_in = 8'd129;
        q.push_back('{sn: 8'd129, due: t + 16});
        wait_idle();
        chk("t3b_sn", {24'd0, pat_sn}, 129);

        // 4: no ack -> timeout after 20 WACK cycles; set wins over clr_err
        ack_en = 1'b0;
        t = cyc;
        dis_sn_in = 8'd131;
        q.push_back('{sn: 8'd131, due: t + 13});
        go_to(t + 32);
        chk("t4_err_pre", {31'd0, err_tmo}, 0);
        clr_err = 1'b1;
        go_to(t + 33);
        chk("t4_err_set", {31'd0, err_tmo}, 1);
        go_to(t + 34);
        chk("t4_err_clr", {31'd0, err_tmo}, 0);
        clr_err = 1'b0;
        go_to(t + 40);
        chk("t4_blank_hold", {31'd0, blank_o}, 1);
        go_to(t + 41);
        chk("t4_blank_off", {31'd0, blank_o}, 0);
        chk("t4_sn", {24'd0, pat_sn}, 131);
        ack_en = 1'b1;

        // 5: change during WACK is ignored, then picked up from IDLE
        repeat (2) @(negedge clk);
        t = cyc;
        dis_sn_in = 8'd132;
        q.push_back('{sn: 8'd132, due: t + 13});
        q.push_back('{sn: 8'd130, due: t + 37});
        go_to(t + 14);
        dis_sn_in = 8'd130;
        go_to(t + 24);
        chk("t5_gap_blank", {31'd0, blank_o}, 0);
        chk("t5_gap_sn", {24'd0, pat_sn}, 132);
        go_to(t + 25);
        chk("t5_reblank", {31'd0, blank_o}, 1);
        wait_idle();
        chk("t5_sn", {24'd0, pat_sn}, 130);

        // pat_ack outside WACK has no effect
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        chk("ack_idle_busy", {31'd0, busy}, 0);

        // 6: reset mid-BLANK aborts with no load
        t = cyc;
        dis_sn_in = 8'd133;
        go_to(t + 5);
        chk("t6_in_blank", {31'd0, blank_o}, 1);
        rst_n = 1'b0;
        dis_sn_in = 8'd127;
        go_to(t + 6);
        chk("t6_blank", {31'd0, blank_o}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_sn", {24'd0, pat_sn}, 127);
        chk("t6_load", {31'd0, pat_load}, 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        chk("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
